float2fixed_pipe: RTL
=====================

// Module: float2fixed_pipe
// PURPOSE
//  Streaming 16-bit float to 43-bit two's-complement fixed-point converter; inverse of fixed2float.
//  Sits on the read side of the neuron accumulator path and expands stored float weights/activations
//  back into full accumulator width. 2-stage pipeline with valid/ready handshake on both sides and
//  full throughput (1 word/cycle). Carries a wrapping count of completed conversions.
// PARAMETERS
//  EXP_W    5   exponent field width
//  MANT_W   10  mantissa field width; MSB is the explicit leading one (no hidden bit)
//  FIXED_W  43  output width; must equal MANT_W + 2**EXP_W + 1
//  CNT_W    16  conversion counter width
// PORTS
//  r_clk           in   1        clock, all logic on rising edge
//  r_reset_n       in   1        synchronous, active-low reset
//  float_in        in   16       {sign, exp[4:0], mant[9:0]}
//  float_in_valid  in   1        float_in holds a word
//  float_in_ready  out  1        block accepts float_in this cycle
//  fixed_out       out  43       two's-complement result
//  fixed_out_valid out  1        fixed_out holds a result
//  fixed_out_ready in   1        downstream accepts fixed_out this cycle
//  conv_count      out  16       number of output handshakes since reset, wraps
// BEHAVIOUR
//  Arithmetic: mag[41:0] = {32'b0, mant} << (exp + 1); no special-case codes, no normalisation.
//   fixed = sign ? (~{1'b0,mag} + 1) : {1'b0,mag}; sign=1 with mag=0 gives 43'h0 (no negative zero).
//   Max magnitude mant=10'h3FF, exp=31 -> 42'h3FF_0000_0000; never overflows, no saturation.
//   Bit-exact inverse of fixed2float for every float with mant[9]=1, or with mant=0 and exp=0.
//  Pipeline: S1 registers {sign, mag} and s1_v; S2 registers the signed fixed value and s2_v.
//   s2_adv = ~s2_v | fixed_out_ready; s1_adv = ~s1_v | s2_adv.
//   float_in_ready = s1_adv (combinational from fixed_out_ready; no combinational path from float_in_valid).
//   Input handshake when float_in_valid & float_in_ready; S1 loads, s1_v <= float_in_valid.
//   When s2_adv: S2 loads S1 contents, s2_v <= s1_v. Stalled stages hold data and valid unchanged.
//   fixed_out = S2 data, fixed_out_valid = s2_v.
//  Latency: 2 cycles from input handshake to fixed_out_valid when not stalled. Throughput 1/cycle.
//  Backpressure: while fixed_out_valid & ~fixed_out_ready, fixed_out must stay stable. Both stages
//   full -> float_in_ready=0. Neither stage drops or duplicates a word. Order is preserved.
//  Simultaneous events: output handshake and input handshake in the same cycle with both stages
//   full are legal; all words shift by one stage with no bubble.
//  conv_count: +1 on each output handshake (fixed_out_valid & fixed_out_ready); wraps 16'hFFFF -> 0.
//  Reset (r_reset_n=0 at r_clk edge): s1_v=s2_v=0, fixed_out=0, fixed_out_valid=0, conv_count=0.
//   float_in_ready reads 1 during reset and the cycle after. Reset mid-stream discards in-flight words.
//   fixed_out_valid first asserts 2 cycles after the first post-reset input handshake.
//  float_in is ignored when float_in_valid=0; X on float_in must not propagate while valid is low.
// TESTING
//  T1 basic: 16'h0200 -> 43'h000_0000_0400 (1024) after 2 cycles with fixed_out_ready held 1.
//  T2 extremes: 16'h7FFF -> 43'h3FF_0000_0000; 16'h8200 -> 43'h7FF_FFFF_FC00; 16'h8000 and 16'h0000 -> 43'h0.
//  T3 throughput: 100 back-to-back words with fixed_out_ready=1 -> 100 results on consecutive cycles,
//   in order, and conv_count=100.
//  T4 backpressure: stream with fixed_out_ready=0 for 5 cycles -> float_in_ready=0 once 2 words are
//   held, fixed_out stays stable; after release all words arrive, none lost or duplicated.
//  T5 reset mid-stream: pulse r_reset_n low with both stages full -> next cycle fixed_out_valid=0,
//   fixed_out=0, conv_count=0; subsequent stream is correct.
//  T6 round-trip: random normalised floats (mant[9]=1) -> float2fixed_pipe -> fixed2float returns
//   the original float bit-exact; plus random ready toggling; conv_count wrap after 65536 outputs.

Source files
------------

// File: rtl/float2fixed_pipe.sv
// Streaming float-to-fixed expander for the neuron accumulator read path.
// Two-stage valid/ready pipeline: S1 holds {sign, magnitude}, S2 holds the signed result.
module float2fixed_pipe #(
    parameter int EXP_W   = 5,
    parameter int MANT_W  = 10,
    parameter int FIXED_W = 43,
    parameter int CNT_W   = 16
) (
    input  logic                   r_clk,
    input  logic                   r_reset_n,
    input  logic [EXP_W+MANT_W:0]  float_in,
    input  logic                   float_in_valid,
    output logic                   float_in_ready,
    output logic [FIXED_W-1:0]     fixed_out,
    output logic                   fixed_out_valid,
    input  logic                   fixed_out_ready,
    output logic [CNT_W-1:0]       conv_count
);

    localparam int MAG_W = FIXED_W - 1;
    localparam logic [EXP_W:0]     SHIFT_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [FIXED_W-1:0] FIXED_ONE = {{(FIXED_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    if (FIXED_W != MANT_W + 2**EXP_W + 1) begin : g_width_check
        $error("FIXED_W must equal MANT_W + 2**EXP_W + 1");
    end

    logic                 in_sign_s;
    logic [EXP_W-1:0]     in_exp_s;
    logic [MANT_W-1:0]    in_mant_s;
    logic [EXP_W:0]       shamt_s;
    logic [MAG_W-1:0]     mag_s;
    logic [FIXED_W-1:0]   fixed_s;
    logic                 s2_adv_s;
    logic                 s1_adv_s;
    logic                 out_hs_s;

    logic                 s1_v_r;
    logic                 s1_sign_r;
    logic [MAG_W-1:0]     s1_mag_r;
    logic                 s2_v_r;
    logic [FIXED_W-1:0]   s2_fixed_r;
    logic [CNT_W-1:0]     cnt_r;

    // Handshake control; ready is forced high while reset is applied
    always_comb begin
        s2_adv_s       = ~s2_v_r | fixed_out_ready;
        s1_adv_s       = ~s1_v_r | s2_adv_s;
        out_hs_s       = s2_v_r & fixed_out_ready;
        float_in_ready = s1_adv_s | ~r_reset_n;
    end

    // Field split and magnitude: the mantissa carries its own leading one, so shift by exp+1
    always_comb begin
        in_sign_s = float_in[EXP_W+MANT_W];
        in_exp_s  = float_in[EXP_W+MANT_W-1:MANT_W];
        in_mant_s = float_in[MANT_W-1:0];
        shamt_s   = {1'b0, in_exp_s} + SHIFT_ONE;
        mag_s     = {{(MAG_W-MANT_W){1'b0}}, in_mant_s} << shamt_s;
    end

    // Two's-complement negation of the S1 magnitude; a zero magnitude stays zero
    always_comb begin
        fixed_s = {1'b0, s1_mag_r};
        if (s1_sign_r) begin
            fixed_s = ~{1'b0, s1_mag_r} + FIXED_ONE;
        end else begin
            fixed_s = {1'b0, s1_mag_r};
        end
    end

    // Stage 1 register: data only loads on a real input word so idle inputs never leak in
    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            s1_v_r    <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_mag_r  <= {MAG_W{1'b0}};
        end else if (s1_adv_s) begin
            s1_v_r <= float_in_valid;
            if (float_in_valid) begin
                s1_sign_r <= in_sign_s;
                s1_mag_r  <= mag_s;
            end else begin
                s1_sign_r <= s1_sign_r;
                s1_mag_r  <= s1_mag_r;
            end
        end else begin
            s1_v_r    <= s1_v_r;
            s1_sign_r <= s1_sign_r;
            s1_mag_r  <= s1_mag_r;
        end
    end

    // Stage 2 register: holds the output word stable while downstream stalls
    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            s2_v_r     <= 1'b0;
            s2_fixed_r <= {FIXED_W{1'b0}};
        end else if (s2_adv_s) begin
            s2_v_r <= s1_v_r;
            if (s1_v_r) begin
                s2_fixed_r <= fixed_s;
            end else begin
                s2_fixed_r <= s2_fixed_r;
            end
        end else begin
            s2_v_r     <= s2_v_r;
            s2_fixed_r <= s2_fixed_r;
        end
    end

    // Completed-conversion counter, wraps naturally at full scale
    always_ff @(posedge r_clk) begin
        if (!r_reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (out_hs_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign fixed_out       = s2_fixed_r;
    assign fixed_out_valid = s2_v_r;
    assign conv_count      = cnt_r;

endmodule
